// File: rtl/game_timer.sv
// game_timer: 3-digit BCD level countdown for the game core.
// tick_src rising edges are prescaled into game-time units. Each unit moves the
// count down by one until it reaches 000. One-cycle pulses mark the hurry
// threshold and time-up.
module game_timer #(
    parameter int INIT_HUND  = 4,
    parameter int INIT_TENS  = 0,
    parameter int INIT_ONES  = 0,
    parameter int TICK_DIV   = 24,
    parameter int HURRY_HUND = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_src,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       running,
    output logic       hurry,
    output logic       time_up,
    output logic       expired
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);
    localparam int INIT_VAL = INIT_HUND * 100 + INIT_TENS * 10 + INIT_ONES;
    localparam bit INIT_ZERO = (INIT_VAL == 0);
    // A level that starts at or below the threshold never announces hurry.
    localparam bit HURRY_EN = (INIT_VAL > HURRY_HUND * 100);
    localparam logic [3:0] INIT_H  = 4'(INIT_HUND);
    localparam logic [3:0] INIT_T  = 4'(INIT_TENS);
    localparam logic [3:0] INIT_O  = 4'(INIT_ONES);
    localparam logic [3:0] HURRY_H = 4'(HURRY_HUND);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          src_q, src_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    hund_q, hund_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          hurry_q, hurry_d;
    logic          time_up_q, time_up_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;

    logic       rise;
    logic       is_zero;
    logic       at_hurry;
    logic       borrow_tens;
    logic       borrow_hund;
    logic [3:0] dec_hund, dec_tens, dec_ones;
    logic       dec_zero;

    // Edge detect and BCD borrow chain for the current count.
    always_comb begin
        rise        = tick_src & ~src_q;
        is_zero     = (hund_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
        at_hurry    = (hund_q == HURRY_H) && (tens_q == 4'd0) && (ones_q == 4'd0);
        borrow_tens = (ones_q == 4'd0);
        borrow_hund = borrow_tens && (tens_q == 4'd0);
        dec_ones    = borrow_tens ? 4'd9 : (ones_q - 4'd1);
        dec_tens    = borrow_tens ? ((tens_q == 4'd0) ? 4'd9 : (tens_q - 4'd1)) : tens_q;
        dec_hund    = borrow_hund ? (hund_q - 4'd1) : hund_q;
        dec_zero    = (dec_hund == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
    end

    // Next-state logic; priority per cycle is load > pause > step > start.
    always_comb begin
        state_d   = state_q;
        src_d     = tick_src;
        pre_d     = pre_q;
        hund_d    = hund_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        hurry_d   = 1'b0;
        time_up_d = 1'b0;

        if (load) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            hund_d  = INIT_H;
            tens_d  = INIT_T;
            ones_d  = INIT_O;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pre_d = '0;
                        if (INIT_ZERO) begin
                            state_d   = ST_EXPIRED;
                            time_up_d = 1'b1;
                        end else if (pause) begin
                            state_d = ST_PAUSE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // A pause on the same cycle as a rise swallows it entirely so
                    // the prescaler phase is unchanged when the pause is released.
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (rise) begin
                        if (pre_q == PRE_MAX) begin
                            pre_d = '0;
                            if (!is_zero) begin
                                hund_d  = dec_hund;
                                tens_d  = dec_tens;
                                ones_d  = dec_ones;
                                hurry_d = HURRY_EN && at_hurry;
                                if (dec_zero) begin
                                    state_d   = ST_EXPIRED;
                                    time_up_d = 1'b1;
                                end
                            end
                        end else begin
                            pre_d = pre_q + PRE_ONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // EXPIRED holds 000 until a load.
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
    end

    // State and output registers; reset returns everything to the reload value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            src_q     <= 1'b0;
            pre_q     <= '0;
            hund_q    <= INIT_H;
            tens_q    <= INIT_T;
            ones_q    <= INIT_O;
            hurry_q   <= 1'b0;
            time_up_q <= 1'b0;
            running_q <= 1'b0;
            expired_q <= INIT_ZERO ? 1'b0 : 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            pre_q     <= pre_d;
            hund_q    <= hund_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            hurry_q   <= hurry_d;
            time_up_q <= time_up_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign bcd_hund = hund_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
    assign running  = running_q;
    assign hurry    = hurry_q;
    assign time_up  = time_up_q;
    assign expired  = expired_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: three instances (INIT 400, 101, 000; TICK_DIV=2) share
// one stimulus stream. An integer-count model is checked every cycle, and
// hand-computed literals pin the key points.
module tb_game_timer;

    logic clk;
    logic rst_n;
    logic tick_src, start, pause, load;

    logic [3:0] d_h [3];
    logic [3:0] d_t [3];
    logic [3:0] d_o [3];
    logic       d_run [3];
    logic       d_hur [3];
    logic       d_tu  [3];
    logic       d_exp [3];

    int tests;
    int fails;

    // model state: integer count, mode 0 idle / 1 run / 2 pause / 3 expired
    int init_v [3] = '{400, 101, 0};
    int cnt  [3];
    int mode [3];
    int pre  [3];
    bit mh   [3];
    bit mt   [3];
    bit src_m;
    localparam int TD = 2;
    localparam int HU = 1;

    game_timer #(.INIT_HUND(4), .INIT_TENS(0), .INIT_ONES(0), .TICK_DIV(TD), .HURRY_HUND(HU)) u0 (
        .clk(clk), .rst(rst_n), .tick_src(tick_src), .start(start), .pause(pause), .load(load),
        .bcd_hund(d_h[0]), .bcd_tens(d_t[0]), .bcd_ones(d_o[0]), .running(d_run[0]),
        .hurry(d_hur[0]), .time_up(d_tu[0]), .expired(d_exp[0]));

    game_timer #(.INIT_HUND(1), .INIT_TENS(0), .INIT_ONES(1), .TICK_DIV(TD), .HURRY_HUND(HU)) u1 (
        .clk(clk), .rst(rst_n), .tick_src(tick_src), .start(start), .pause(pause), .load(load),
        .bcd_hund(d_h[1]), .bcd_tens(d_t[1]), .bcd_ones(d_o[1]), .running(d_run[1]),
        .hurry(d_hur[1]), .time_up(d_tu[1]), .expired(d_exp[1]));

    game_timer #(.INIT_HUND(0), .INIT_TENS(0), .INIT_ONES(0), .TICK_DIV(TD), .HURRY_HUND(HU)) u2 (
        .clk(clk), .rst(rst_n), .tick_src(tick_src), .start(start), .pause(pause), .load(load),
        .bcd_hund(d_h[2]), .bcd_tens(d_t[2]), .bcd_ones(d_o[2]), .running(d_run[2]),
        .hurry(d_hur[2]), .time_up(d_tu[2]), .expired(d_exp[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            cnt[k]  = init_v[k];
            mode[k] = 0;
            pre[k]  = 0;
            mh[k]   = 1'b0;
            mt[k]   = 1'b0;
        end
        src_m = 1'b0;
    endtask

    // One clock edge of the game rules, applied to the integer count.
    task automatic model_update();
        bit r;
        if (!rst_n) begin
            model_reset();
            return;
        end
        r = tick_src & ~src_m;
        src_m = tick_src;
        for (int k = 0; k < 3; k++) begin
            mh[k] = 1'b0;
            mt[k] = 1'b0;
            if (load) begin
                mode[k] = 0;
                cnt[k]  = init_v[k];
                pre[k]  = 0;
            end else if (mode[k] == 0) begin
                if (start) begin
                    pre[k] = 0;
                    if (init_v[k] == 0) begin
                        mode[k] = 3;
                        mt[k]   = 1'b1;
                    end else begin
                        mode[k] = pause ? 2 : 1;
                    end
                end
            end else if (mode[k] == 1) begin
                if (pause) begin
                    mode[k] = 2;
                end else if (r) begin
                    pre[k] = (pre[k] + 1) % TD;
                    if (pre[k] == 0 && cnt[k] > 0) begin
                        cnt[k] = cnt[k] - 1;
                        if (cnt[k] == HU * 100 - 1 && init_v[k] > HU * 100) mh[k] = 1'b1;
                        if (cnt[k] == 0) begin
                            mode[k] = 3;
                            mt[k]   = 1'b1;
                        end
                    end
                end
            end else if (mode[k] == 2) begin
                if (!pause) mode[k] = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [15:0] act, exp;
        for (int k = 0; k < 3; k++) begin
            act = {d_h[k], d_t[k], d_o[k], d_run[k], d_hur[k], d_tu[k], d_exp[k]};
            exp = {4'(cnt[k] / 100), 4'((cnt[k] / 10) % 10), 4'(cnt[k] % 10),
                   (mode[k] == 1), mh[k], mt[k], (mode[k] == 3)};
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL model_u%0d t=%0t got=%h want=%h (hund,tens,ones,run|hurry|tu|exp)",
                         k, $time, act, exp);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end else begin
            $display("[TB] %s ok (%0h)", name, act);
        end
    endtask

    // Advance n cycles: model steps on each rising edge, compare on falling edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic rise_n(input int n);
        repeat (n) begin
            tick_src = 1'b1;
            cyc(1);
            tick_src = 1'b0;
            cyc(1);
        end
    endtask

    function automatic int digits(input int k);
        return int'({d_h[k], d_t[k], d_o[k]});
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        tick_src = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        load = 1'b0;
        model_reset();
        cyc(2);
        chk("reset_digits", digits(0), 'h400);
        chk("reset_running", int'(d_run[0]), 0);

        // 1: no start, ticks must not move the count
        rst_n = 1'b1;
        rise_n(10);
        chk("idle_digits", digits(0), 'h400);
        chk("idle_running", int'(d_run[0]), 0);

        // 2: start then first borrow 400 -> 399 -> 398
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("start_running", int'(d_run[0]), 1);
        chk("zero_init_time_up", int'(d_tu[2]), 1);
        chk("zero_init_expired", int'(d_exp[2]), 1);
        cyc(1);
        chk("zero_init_pulse_end", int'(d_tu[2]), 0);
        rise_n(2);
        chk("first_step_399", digits(0), 'h399);
        rise_n(1);
        tick_src = 1'b1;
        cyc(1);
        chk("step_398", digits(0), 'h398);
        chk("hurry_pulse", int'(d_hur[1]), 1);
        chk("hurry_digits_099", digits(1), 'h099);
        tick_src = 1'b0;
        cyc(1);
        chk("hurry_pulse_end", int'(d_hur[1]), 0);

        // 3: run u1 down to 000
        rise_n(197);
        chk("u1_at_001", digits(1), 'h001);
        tick_src = 1'b1;
        cyc(1);
        chk("time_up_pulse", int'(d_tu[1]), 1);
        chk("expired_set", int'(d_exp[1]), 1);
        chk("u1_at_000", digits(1), 'h000);
        tick_src = 1'b0;
        cyc(1);
        chk("time_up_pulse_end", int'(d_tu[1]), 0);
        chk("u0_at_299", digits(0), 'h299);

        // 4: pause on a qualifying rise, then level-high tick counts once
        rise_n(1);
        pause = 1'b1;
        tick_src = 1'b1;
        cyc(1);
        chk("pause_no_dec", digits(0), 'h299);
        chk("pause_running", int'(d_run[0]), 0);
        tick_src = 1'b0;
        cyc(1);
        pause = 1'b0;
        cyc(1);
        chk("resume_running", int'(d_run[0]), 1);
        tick_src = 1'b1;
        cyc(1);
        chk("resume_phase_dec", digits(0), 'h298);
        tick_src = 1'b0;
        cyc(1);
        tick_src = 1'b1;
        cyc(50);
        chk("level_counts_once", digits(0), 'h298);
        tick_src = 1'b0;
        cyc(1);
        tick_src = 1'b1;
        cyc(1);
        chk("after_level_297", digits(0), 'h297);
        tick_src = 1'b0;
        cyc(1);

        // 5: load in RUN at 237 and in EXPIRED; start ignored in EXPIRED
        rise_n(120);
        chk("u0_at_237", digits(0), 'h237);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("start_ignored_expired", int'(d_exp[1]), 1);
        chk("start_ignored_digits", digits(1), 'h000);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("load_run_digits", digits(0), 'h400);
        chk("load_run_idle", int'(d_run[0]), 0);
        chk("load_no_pulse", int'({d_hur[0], d_tu[0], d_hur[1], d_tu[1]}), 0);
        chk("load_exp_digits", digits(1), 'h101);
        chk("load_exp_cleared", int'(d_exp[1]), 0);
        cyc(1);

        // 6: run to 312, asynchronous reset mid-count
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("zero_init_restart_tu", int'(d_tu[2]), 1);
        rise_n(176);
        chk("u0_at_312", digits(0), 'h312);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_digits", digits(0), 'h400);
        chk("async_rst_running", int'(d_run[0]), 0);
        chk("async_rst_expired", int'(d_exp[2]), 0);
        cyc(2);
        rst_n = 1'b1;
        rise_n(3);
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
